// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for a 5-stage MIPS pipeline.
// It captures the register-file operands, the immediate and the decode
// controls, and resolves the destination register. It also detects load-use
// hazards and inserts a single bubble, and it applies branch flushes.
// Optional feature macro: ID_EX_STALL_CNT_EN adds a saturating counter of
// load-use stall cycles on stall_cnt. Without the macro, stall_cnt is tied to 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic              flush,
    output logic              hz_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [3:0]        ex_alu_op,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_sd_q, ex_sd_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;
    logic              ex_mw_q, ex_mw_d;
    logic [3:0]        ex_op_q, ex_op_d;

    logic              hz;
    logic [REG_AW-1:0] dest_sel;

    // Load-use hazard: the load now in EX produces a register that the ID instruction reads.
    always_comb begin
        hz = id_valid & ex_valid_q & ex_mr_q & (ex_dest_q != '0)
             & ((ex_dest_q == id_rs) | (ex_dest_q == id_rt));
        hz_stall = hz & ~flush & ~rst;
    end

    // Next EX bundle. A flush and a hazard bubble both clear the controls
    // and leave the data registers holding their old values.
    always_comb begin
        dest_sel   = id_reg_dst ? id_rd : id_rt;
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_sd_d    = ex_sd_q;
        ex_dest_d  = ex_dest_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rw_d    = ex_rw_q;
        ex_mr_d    = ex_mr_q;
        ex_mw_d    = ex_mw_q;
        ex_op_d    = ex_op_q;
        if (flush || hz) begin
            ex_valid_d = 1'b0;
            ex_rw_d    = 1'b0;
            ex_mr_d    = 1'b0;
            ex_mw_d    = 1'b0;
            ex_op_d    = '0;
        end else begin
            ex_valid_d = id_valid;
            ex_a_d     = id_rd1;
            ex_b_d     = id_alu_src ? id_imm : id_rd2;
            ex_sd_d    = id_rd2;
            ex_dest_d  = dest_sel;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_rw_d    = id_reg_write & id_valid & (dest_sel != '0);
            ex_mr_d    = id_mem_read & id_valid;
            ex_mw_d    = id_mem_write & id_valid;
            ex_op_d    = id_alu_op;
        end
    end

    // EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_sd_q    <= '0;
            ex_dest_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_op_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_sd_q    <= ex_sd_d;
            ex_dest_q  <= ex_dest_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            ex_mw_q    <= ex_mw_d;
            ex_op_q    <= ex_op_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles spent in a load-use stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign ex_valid      = ex_valid_q;
    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_store_data = ex_sd_q;
    assign ex_dest       = ex_dest_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_reg_write  = ex_rw_q;
    assign ex_mem_read   = ex_mr_q;
    assign ex_mem_write  = ex_mw_q;
    assign ex_alu_op     = ex_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios followed by randomized instruction
// streams. All outputs are checked against a behavioural model of the EX stage.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic              id_reg_write, id_mem_read, id_mem_write, id_reg_dst, id_alu_src;
    logic [3:0]        id_alu_op;
    logic              flush;
    logic              hz_stall, ex_valid;
    logic [DATA_W-1:0] ex_a, ex_b, ex_store_data;
    logic [REG_AW-1:0] ex_dest, ex_rs, ex_rt;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]        ex_alu_op;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of what the EX stage should hold.
    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] a, b, sd;
        logic [REG_AW-1:0] dest, rs, rt;
        logic              rw, mr, mw;
        logic [3:0]        op;
    } ex_t;
    ex_t m;
    int  m_cnt;
    logic last_stall;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .flush(flush), .hz_stall(hz_stall), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
        .stall_cnt(stall_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The stall the model predicts for the current ID inputs.
    function automatic logic model_stall();
        logic uses;
        uses = (m.dest == id_rs) || (m.dest == id_rt);
        return !rst && !flush && id_valid && m.valid && m.mr && (m.dest != 0) && uses;
    endfunction

    function automatic int cnt_max();
        return (1 << CNT_W) - 1;
    endfunction

    // Advance the model by one clock edge, following the priority rst > flush > hazard > load.
    task automatic model_update();
        logic [REG_AW-1:0] d;
        logic stall;
        stall = model_stall();
        last_stall = stall;
        if (rst) begin
            m = '{default: '0};
            m_cnt = 0;
        end else if (flush || stall) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.op = 0;
        end else begin
            d = id_reg_dst ? id_rd : id_rt;
            m.valid = id_valid;
            m.a = id_rd1;
            m.b = id_alu_src ? id_imm : id_rd2;
            m.sd = id_rd2;
            m.dest = d;
            m.rs = id_rs;
            m.rt = id_rt;
            m.rw = id_reg_write && id_valid && (d != 0);
            m.mr = id_mem_read && id_valid;
            m.mw = id_mem_write && id_valid;
            m.op = id_alu_op;
        end
`ifdef ID_EX_STALL_CNT_EN
        if (stall && m_cnt < cnt_max()) m_cnt++;
`endif
    endtask

    task automatic check_outputs();
        check_eq("ex_valid", ex_valid, m.valid);
        check_eq("ex_a", ex_a, m.a);
        check_eq("ex_b", ex_b, m.b);
        check_eq("ex_store_data", ex_store_data, m.sd);
        check_eq("ex_dest", ex_dest, m.dest);
        check_eq("ex_rs", ex_rs, m.rs);
        check_eq("ex_rt", ex_rt, m.rt);
        check_eq("ex_reg_write", ex_reg_write, m.rw);
        check_eq("ex_mem_read", ex_mem_read, m.mr);
        check_eq("ex_mem_write", ex_mem_write, m.mw);
        check_eq("ex_alu_op", ex_alu_op, m.op);
        check_eq("stall_cnt", stall_cnt, m_cnt);
    endtask

    // One cycle: check hz_stall, step through the posedge, then check the EX bundle.
    task automatic tick();
        #1;
        check_eq("hz_stall", hz_stall, model_stall());
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_id(input logic v, input int rs, input int rt, input int rd,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic rw, input logic mr,
                            input logic mw, input logic rdst, input logic asrc,
                            input logic [3:0] op, input logic fl);
        id_valid = v; id_rs = rs[REG_AW-1:0]; id_rt = rt[REG_AW-1:0]; id_rd = rd[REG_AW-1:0];
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_reg_dst = rdst; id_alu_src = asrc; id_alu_op = op; flush = fl;
    endtask

    task automatic drive_random();
        int kind;
        kind = $urandom_range(0, 3);
        id_valid = ($urandom_range(0, 7) != 0);
        id_rs = REG_AW'($urandom_range(0, 3));
        id_rt = REG_AW'($urandom_range(0, 3));
        id_rd = REG_AW'($urandom_range(0, 3));
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_reg_write = (kind != 2);
        id_mem_read = (kind == 1);
        id_mem_write = (kind == 2);
        id_reg_dst = (kind == 0);
        id_alu_src = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        id_alu_op = 4'($urandom_range(0, 15));
    endtask

    initial begin
        m = '{default: '0};
        m_cnt = 0;
        last_stall = 0;
        rst = 1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        @(negedge clk);

        // Reset held for two clocks.
        #1 check_eq("rst_hz_stall", hz_stall, 0);
        tick();
        tick();
        check_eq("rst_ex_valid", ex_valid, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        rst = 0;

        // add $3,$1,$2 with rd1=5, rd2=7.
        drive_id(1, 1, 2, 3, 5, 7, 0, 1, 0, 0, 1, 0, 4'h2, 0);
        tick();
        check_eq("add_ex_a", ex_a, 5);
        check_eq("add_ex_b", ex_b, 7);
        check_eq("add_ex_dest", ex_dest, 3);
        check_eq("add_reg_write", ex_reg_write, 1);
        check_eq("add_ex_valid", ex_valid, 1);

        // lw $8,4($9) followed by add $10,$8,$1: one bubble, then the add.
        drive_id(1, 9, 8, 0, 32'h100, 32'h0, 4, 1, 1, 0, 0, 1, 4'h2, 0);
        tick();
        drive_id(1, 8, 1, 10, 32'h11, 32'h22, 0, 1, 0, 0, 1, 0, 4'h2, 0);
        #1 check_eq("lu_hz_stall", hz_stall, 1);
        tick();
        check_eq("lu_bubble", ex_valid, 0);
        #1 check_eq("lu_hz_clear", hz_stall, 0);
        tick();
        check_eq("lu_add_valid", ex_valid, 1);
        check_eq("lu_add_dest", ex_dest, 10);
`ifdef ID_EX_STALL_CNT_EN
        check_eq("lu_stall_cnt", stall_cnt, 1);
`endif

        // lw $0 then a use of $0: no stall.
        drive_id(1, 9, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, 4'h2, 0);
        tick();
        drive_id(1, 0, 0, 4, 1, 2, 0, 1, 0, 0, 1, 0, 4'h2, 0);
        #1 check_eq("zero_no_stall", hz_stall, 0);
        tick();
        // addi writing $0 never asserts reg_write.
        drive_id(1, 1, 0, 0, 3, 0, 9, 1, 0, 0, 0, 1, 4'h2, 0);
        tick();
        check_eq("addi_zero_rw", ex_reg_write, 0);

        // Flush concurrent with a load-use hazard.
        drive_id(1, 9, 8, 0, 32'h100, 0, 4, 1, 1, 0, 0, 1, 4'h2, 0);
        tick();
        drive_id(1, 8, 1, 10, 1, 2, 0, 1, 0, 0, 1, 0, 4'h2, 1);
        #1 check_eq("flush_hz_stall", hz_stall, 0);
        tick();
        check_eq("flush_ex_valid", ex_valid, 0);
        check_eq("flush_stall_cnt", stall_cnt, m_cnt);

        // Same-cycle WB write of $5 shows up in readData1.
        drive_id(1, 5, 2, 6, 32'hAB, 1, 0, 1, 0, 0, 1, 0, 4'h2, 0);
        tick();
        check_eq("wb_ex_a", ex_a, 32'hAB);

        // Randomized streams; upstream holds the ID instruction while stalled.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            if (!last_stall) drive_random();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
